// File: rtl/adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// adc_capture_buffer
//
// Triggered acquisition buffer placed behind the AD9276 deserializer. After
// ARM, the block waits for a rising edge on TRIGGER, discards DELAY frames,
// then stores NUM_SAMPLES frames (clamped to the buffer depth) into an
// on-chip simple dual-port RAM. The host reads stored frames back through a
// registered random-access port with one cycle of latency.
//
// Optional feature (macro ADC_CAPTURE_TEST_PATTERN_EN):
//   Adds input TEST_MODE. When TEST_MODE=1 during CAPTURE, channel k of the
//   n-th stored frame is (n + k) mod 2^SAMPLE_WIDTH instead of DIN.
//
// Ports:
//   CLK          frame-domain clock, rising edge
//   RESET        asynchronous, active-high reset
//   LOAD         frame strobe, DIN valid when high
//   DIN          packed channel frame, channel A in the LSBs
//   ARM          pulse: latch DELAY/NUM_SAMPLES and arm (IDLE/DONE only)
//   ABORT        pulse: return to IDLE
//   TRIGGER      synchronous level, rising edge starts acquisition
//   DELAY        frames discarded after the trigger edge
//   NUM_SAMPLES  frames to store
//   RD_ADDR      readback address
//   TEST_MODE    (optional) store the test pattern instead of DIN
//   RD_DATA      registered readback data
//   BUSY         high in ARMED, DELAY, CAPTURE
//   DONE         high in DONE
//   STATE        IDLE=0, ARMED=1, DELAY=2, CAPTURE=3, DONE=4
//   WR_COUNT     frames stored in the current/last acquisition
// ---------------------------------------------------------------------------
module adc_capture_buffer #(
    parameter int NUM_CH       = 8,
    parameter int SAMPLE_WIDTH = 12,
    parameter int ADDR_WIDTH   = 12,
    parameter int DELAY_WIDTH  = 16
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             LOAD,
    input  logic [NUM_CH*SAMPLE_WIDTH-1:0]   DIN,
    input  logic                             ARM,
    input  logic                             ABORT,
    input  logic                             TRIGGER,
    input  logic [DELAY_WIDTH-1:0]           DELAY,
    input  logic [ADDR_WIDTH:0]              NUM_SAMPLES,
    input  logic [ADDR_WIDTH-1:0]            RD_ADDR,
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    input  logic                             TEST_MODE,
`endif
    output logic [NUM_CH*SAMPLE_WIDTH-1:0]   RD_DATA,
    output logic                             BUSY,
    output logic                             DONE,
    output logic [2:0]                       STATE,
    output logic [ADDR_WIDTH:0]              WR_COUNT
);

    localparam int DATA_WIDTH = NUM_CH * SAMPLE_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_DELAY   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Largest storable frame count: exactly the buffer depth.
    localparam logic [ADDR_WIDTH:0] MAX_FRAMES = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [2:0]              r_state;
    logic                    r_trig_q;
    logic [DELAY_WIDTH-1:0]  r_dly_cnt;
    logic [ADDR_WIDTH:0]     r_num_lat;
    logic [ADDR_WIDTH:0]     r_wr_count;
    logic [DATA_WIDTH-1:0]   r_rd_data;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_trig_rise;
    logic [ADDR_WIDTH:0]     w_num_clamped;
    logic [ADDR_WIDTH:0]     w_wr_next;
    logic                    w_wr_en;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;

    assign w_trig_rise   = TRIGGER & ~r_trig_q;
    assign w_num_clamped = (NUM_SAMPLES > MAX_FRAMES) ? MAX_FRAMES : NUM_SAMPLES;
    assign w_wr_next     = r_wr_count + 1'b1;
    assign w_wr_addr     = r_wr_count[ADDR_WIDTH-1:0];

    // A zero latched count never writes; ABORT suppresses the in-flight frame.
    assign w_wr_en = (r_state == ST_CAPTURE) && LOAD && !ABORT && (r_num_lat != '0);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first,
        // otherwise paths that skip the assignment infer a latch.
        w_wr_data = DIN;
        if (TEST_MODE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_wr_data[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                    SAMPLE_WIDTH'(int'(r_wr_count) + k);
            end
        end
    end
`else
    assign w_wr_data = DIN;
`endif

    // Control FSM. ABORT outranks ARM, which outranks trigger/LOAD activity.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_trig_q   <= 1'b0;
            r_dly_cnt  <= '0;
            r_num_lat  <= '0;
            r_wr_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            r_trig_q <= TRIGGER;
            if (ABORT) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (ARM) begin
                            r_state    <= ST_ARMED;
                            r_dly_cnt  <= DELAY;
                            r_num_lat  <= w_num_clamped;
                            r_wr_count <= '0;
                        end
                    end
                    ST_ARMED: begin
                        // The frame coinciding with the trigger edge is dropped.
                        if (w_trig_rise) begin
                            r_state <= (r_dly_cnt != '0) ? ST_DELAY : ST_CAPTURE;
                        end
                    end
                    ST_DELAY: begin
                        if (LOAD) begin
                            r_dly_cnt <= r_dly_cnt - 1'b1;
                            if (r_dly_cnt == DELAY_WIDTH'(1)) begin
                                r_state <= ST_CAPTURE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        if (r_num_lat == '0) begin
                            r_state <= ST_DONE;
                        end else if (LOAD) begin
                            r_wr_count <= w_wr_next;
                            if (w_wr_next == r_num_lat) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: the RAM array has no reset so it maps onto block RAM; its
    // contents survive RESET by design.
    always_ff @(posedge CLK) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Registered read; a same-address write on this edge returns old data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[RD_ADDR];
        end
    end

    assign RD_DATA  = r_rd_data;
    assign BUSY     = (r_state == ST_ARMED) || (r_state == ST_DELAY) ||
                      (r_state == ST_CAPTURE);
    assign DONE     = (r_state == ST_DONE);
    assign STATE    = r_state;
    assign WR_COUNT = r_wr_count;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_buffer
//
// Directed bench for adc_capture_buffer. Readback requests push the expected
// frame into a queue; a monitor pops and compares one cycle later when the
// registered RD_DATA becomes valid. Status outputs are checked directly.
// ---------------------------------------------------------------------------
module tb_adc_capture_buffer;

    localparam int NCH = 8;
    localparam int SW  = 12;
    localparam int AW  = 12;
    localparam int DW  = NCH * SW;

    logic            clk = 1'b0;
    logic            reset;
    logic            load;
    logic [DW-1:0]   din;
    logic            arm;
    logic            abort;
    logic            trigger;
    logic [15:0]     delay;
    logic [AW:0]     num_samples;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            busy;
    logic            done;
    logic [2:0]      state;
    logic [AW:0]     wr_count;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic            test_mode;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t exp_q[$];
    logic    rd_req = 1'b0;
    logic    rd_pending = 1'b0;

    adc_capture_buffer dut (
        .CLK         (clk),
        .RESET       (reset),
        .LOAD        (load),
        .DIN         (din),
        .ARM         (arm),
        .ABORT       (abort),
        .TRIGGER     (trigger),
        .DELAY       (delay),
        .NUM_SAMPLES (num_samples),
        .RD_ADDR     (rd_addr),
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        .TEST_MODE   (test_mode),
`endif
        .RD_DATA     (rd_data),
        .BUSY        (busy),
        .DONE        (done),
        .STATE       (state),
        .WR_COUNT    (wr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rep(input logic [SW-1:0] v);
        return {NCH{v}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [15:0] d, input logic [AW:0] n);
        arm = 1'b1; delay = d; num_samples = n;
        step();
        arm = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        rd_exp_t item;
        item.addr = a;
        item.data = e;
        exp_q.push_back(item);
        rd_addr = a;
        rd_req  = 1'b1;
        step();
        rd_req  = 1'b0;
        step();
    endtask

    task automatic check_status(input string tag, input logic [2:0] st,
                                input logic [AW:0] wc);
        check({tag, "_state"}, DW'(state), DW'(st));
        check({tag, "_wr_count"}, DW'(wr_count), DW'(wc));
        check({tag, "_busy"}, DW'(busy), DW'(st == 3'd1 || st == 3'd2 || st == 3'd3));
        check({tag, "_done"}, DW'(done), DW'(st == 3'd4));
    endtask

    // Scoreboard monitor: RD_DATA is valid the cycle after a request.
    always @(posedge clk) rd_pending <= rd_req;

    always @(negedge clk) begin
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected actual=%h required=none", rd_data);
            end else begin
                rd_exp_t item;
                item = exp_q.pop_front();
                n_checks++;
                if (rd_data !== item.data) begin
                    n_errors++;
                    $display("FAIL rd_addr_%0d actual=%h expected=%h",
                             item.addr, rd_data, item.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; load = 1'b0; din = '0; arm = 1'b0; abort = 1'b0;
        trigger = 1'b0; delay = '0; num_samples = '0; rd_addr = '0;
`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        test_mode = 1'b0;
`endif
        step(); step();
        reset = 1'b0;
        check_status("reset", 3'd0, '0);
        check("reset_rd_data", rd_data, '0);

        // Reset mid-CAPTURE after 5 writes.
        do_arm(16'd0, 13'd10);
        trigger = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            load = 1'b1; din = rep(12'(12'h100 + i));
            step();
        end
        load = 1'b0;
        check_status("midcap", 3'd3, 13'd5);
        rd(12'd0, rep(12'h100));
        reset = 1'b1;
        step();
        check_status("midcap_reset", 3'd0, '0);
        check("midcap_reset_rd_data", rd_data, '0);
        reset = 1'b0; trigger = 1'b0;
        step();
        rd(12'd4, rep(12'h104));   // RAM survives reset

        // DELAY=3, NUM_SAMPLES=4, ten frames valued 0..9.
        do_arm(16'd3, 13'd4);
        check_status("armed", 3'd1, '0);
        trigger = 1'b1;
        step();
        check_status("delay", 3'd2, '0);
        for (int i = 0; i < 10; i++) begin
            load = 1'b1; din = rep(12'(i));
            step();
        end
        load = 1'b0; trigger = 1'b0;
        check_status("dly3", 3'd4, 13'd4);
        for (int i = 0; i < 4; i++) rd(12'(i), rep(12'(i + 3)));

        // DELAY=0: frame coinciding with the trigger edge is dropped.
        do_arm(16'd0, 13'd2);
        check_status("rearm", 3'd1, '0);
        trigger = 1'b1; load = 1'b1; din = rep(12'hAAA);
        step();
        din = rep(12'h001); step();
        din = rep(12'h002); step();
        load = 1'b0; trigger = 1'b0;
        check_status("dly0", 3'd4, 13'd2);
        rd(12'd0, rep(12'h001));
        rd(12'd1, rep(12'h002));

        // NUM_SAMPLES=0: DONE one cycle after entering CAPTURE, no writes.
        do_arm(16'd0, 13'd0);
        trigger = 1'b1;
        step();
        check_status("n0_cap", 3'd3, '0);
        load = 1'b1; din = rep(12'h555);
        step();
        load = 1'b0; trigger = 1'b0;
        check_status("n0_done", 3'd4, '0);
        rd(12'd0, rep(12'h001));

        // NUM_SAMPLES=8191 clamps to the 4096-frame depth.
        do_arm(16'd0, 13'd8191);
        trigger = 1'b1;
        step();
        for (int i = 0; i < 4100; i++) begin
            load = 1'b1;
            din  = (i < 4096) ? rep(12'(i)) : rep(12'hABC);
            step();
            if (i == 4094) check_status("clamp_4095", 3'd3, 13'd4095);
        end
        load = 1'b0; trigger = 1'b0;
        check_status("clamp", 3'd4, 13'd4096);
        rd(12'd0, rep(12'd0));
        rd(12'd4095, rep(12'd4095));

        // ABORT during DELAY, then a second trigger edge stays in IDLE.
        do_arm(16'd5, 13'd2);
        trigger = 1'b1;
        step();
        load = 1'b1; din = rep(12'h777);
        step(); step();
        abort = 1'b1;
        step();
        abort = 1'b0; load = 1'b0; trigger = 1'b0;
        check_status("abort_dly", 3'd0, '0);
        step();
        trigger = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            load = 1'b1; din = rep(12'h777);
            step();
        end
        load = 1'b0; trigger = 1'b0;
        check_status("abort_retrig", 3'd0, '0);
        rd(12'd0, rep(12'd0));
        rd(12'd1, rep(12'd1));

        // ABORT during CAPTURE: WR_COUNT holds, in-flight frame not written.
        do_arm(16'd0, 13'd5);
        trigger = 1'b1;
        step();
        load = 1'b1;
        din = rep(12'h321); step();
        din = rep(12'h322); step();
        din = rep(12'h999); abort = 1'b1; step();
        abort = 1'b0; load = 1'b0; trigger = 1'b0;
        check_status("abort_cap", 3'd0, 13'd2);
        rd(12'd1, rep(12'h322));
        rd(12'd2, rep(12'd2));

        // ARM while in CAPTURE is ignored.
        do_arm(16'd0, 13'd3);
        trigger = 1'b1;
        step();
        load = 1'b1; din = rep(12'h010); step();
        arm = 1'b1; delay = 16'd7; num_samples = 13'd1;
        din = rep(12'h011); step();
        arm = 1'b0;
        load = 1'b0;
        check_status("arm_in_cap", 3'd3, 13'd2);
        load = 1'b1; din = rep(12'h012); step();
        load = 1'b0; trigger = 1'b0;
        check_status("arm_in_cap_done", 3'd4, 13'd3);
        for (int i = 0; i < 3; i++) rd(12'(i), rep(12'(12'h010 + i)));

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
        // Test pattern: channel k of frame n = n + k.
        test_mode = 1'b1;
        do_arm(16'd0, 13'd3);
        trigger = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; din = rep(12'hFFF);
            step();
        end
        load = 1'b0; trigger = 1'b0; test_mode = 1'b0;
        check_status("pattern", 3'd4, 13'd3);
        for (int n = 0; n < 3; n++) begin
            logic [DW-1:0] e;
            for (int k = 0; k < NCH; k++) e[k*SW +: SW] = 12'(n + k);
            rd(12'(n), e);
        end
`endif

        step(); step();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
